// File: rtl/csr_trap_unit.sv
// Machine-mode trap (ECALL) and trap-return (MRET) sequencer that sits in front of the CSR file.
// Optional build macro TRAP_EBREAK_EN adds an is_ebreak request input (mcause 3).
module csr_trap_unit #(
    parameter int DATA_WIDTH    = 64,
    parameter int CSRADDR_WIDTH = 12,
    parameter int ECALL_CAUSE   = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     is_ecall,
    input  logic                     is_mret,
`ifdef TRAP_EBREAK_EN
    input  logic                     is_ebreak,
`endif
    input  logic [DATA_WIDTH-1:0]    pc,
    output logic [CSRADDR_WIDTH-1:0] rcsaddr,
    input  logic [DATA_WIDTH-1:0]    rcsdata,
    output logic                     csr_wen,
    output logic [CSRADDR_WIDTH-1:0] wcsaddr1,
    output logic [DATA_WIDTH-1:0]    wcsdata1,
    output logic [CSRADDR_WIDTH-1:0] wcsaddr2,
    output logic [DATA_WIDTH-1:0]    wcsdata2,
    output logic                     busy,
    output logic                     redirect_valid,
    output logic [DATA_WIDTH-1:0]    redirect_pc
);

    localparam logic [CSRADDR_WIDTH-1:0] ADDR_MSTATUS = CSRADDR_WIDTH'(12'h300);
    localparam logic [CSRADDR_WIDTH-1:0] ADDR_MTVEC   = CSRADDR_WIDTH'(12'h305);
    localparam logic [CSRADDR_WIDTH-1:0] ADDR_MEPC    = CSRADDR_WIDTH'(12'h341);
    localparam logic [CSRADDR_WIDTH-1:0] ADDR_MCAUSE  = CSRADDR_WIDTH'(12'h342);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_A      = 3'd1,
        RD_STATUS = 3'd2,
        WR_EPC    = 3'd3,
        WR_STATUS = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   pc_q;
    logic [DATA_WIDTH-1:0]   target_q;
    logic [DATA_WIDTH-1:0]   status_q;
    logic [DATA_WIDTH-1:0]   status_new;
    logic [DATA_WIDTH-1:0]   cause_val;
    logic                    trap_q;
    logic                    req_trap;
    logic                    accept;

    // A "trap" request is anything that enters through mtvec; MRET is the only other kind.
`ifdef TRAP_EBREAK_EN
    logic brk_q;
    logic req_brk;
    assign req_trap  = is_ecall | is_ebreak;
    assign req_brk   = ~is_ecall & is_ebreak;
    assign cause_val = brk_q ? DATA_WIDTH'(3) : DATA_WIDTH'(ECALL_CAUSE);
`else
    assign req_trap  = is_ecall;
    assign cause_val = DATA_WIDTH'(ECALL_CAUSE);
`endif

    assign accept = req_valid & (state == IDLE) & (req_trap | is_mret);

    always_comb begin
        status_new = status_q;
        if (trap_q) begin
            status_new[7]     = status_q[3];
            status_new[3]     = 1'b0;
            status_new[12:11] = 2'b11;
        end else begin
            status_new[3]     = status_q[7];
            status_new[7]     = 1'b1;
            status_new[12:11] = 2'b11;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc_q     <= '0;
            target_q <= '0;
            status_q <= '0;
            trap_q   <= 1'b0;
`ifdef TRAP_EBREAK_EN
            brk_q    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                pc_q   <= pc;
                trap_q <= req_trap;
`ifdef TRAP_EBREAK_EN
                brk_q  <= req_brk;
`endif
            end
            // Only direct-mode mtvec is supported, so the mode bits are simply dropped.
            if (state == RD_A)
                target_q <= trap_q ? {rcsdata[DATA_WIDTH-1:2], 2'b00} : rcsdata;
            if (state == RD_STATUS)
                status_q <= rcsdata;
        end
    end

    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        busy           = 1'b1;
        rcsaddr        = ADDR_MSTATUS;
        csr_wen        = 1'b0;
        wcsaddr1       = '0;
        wcsdata1       = '0;
        wcsaddr2       = '0;
        wcsdata2       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                rcsaddr   = '0;
                if (accept)
                    state_next = RD_A;
            end
            RD_A: begin
                rcsaddr    = trap_q ? ADDR_MTVEC : ADDR_MEPC;
                state_next = RD_STATUS;
            end
            RD_STATUS: begin
                rcsaddr    = ADDR_MSTATUS;
                state_next = trap_q ? WR_EPC : WR_STATUS;
            end
            WR_EPC: begin
                csr_wen    = 1'b1;
                wcsaddr1   = ADDR_MEPC;
                wcsdata1   = pc_q;
                wcsaddr2   = ADDR_MCAUSE;
                wcsdata2   = cause_val;
                state_next = WR_STATUS;
            end
            WR_STATUS: begin
                // Both ports carry the same write so the file's unconditional dual write is harmless.
                csr_wen    = 1'b1;
                wcsaddr1   = ADDR_MSTATUS;
                wcsdata1   = status_new;
                wcsaddr2   = ADDR_MSTATUS;
                wcsdata2   = status_new;
                state_next = DONE;
            end
            DONE: begin
                busy           = 1'b0;
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: a small CSR file model plus directed vector table and corner sequences.
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        is_ecall = 1'b0;
    logic        is_mret = 1'b0;
    logic [63:0] pc = '0;
    logic [11:0] rcsaddr;
    logic [63:0] rcsdata;
    logic        csr_wen;
    logic [11:0] wcsaddr1;
    logic [63:0] wcsdata1;
    logic [11:0] wcsaddr2;
    logic [63:0] wcsdata2;
    logic        busy;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
`ifdef TRAP_EBREAK_EN
    logic        is_ebreak = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] m_mtvec, m_mepc, m_mcause, m_mstatus;

    always #5 clk = ~clk;

    csr_trap_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_ecall(is_ecall), .is_mret(is_mret),
`ifdef TRAP_EBREAK_EN
        .is_ebreak(is_ebreak),
`endif
        .pc(pc), .rcsaddr(rcsaddr), .rcsdata(rcsdata), .csr_wen(csr_wen),
        .wcsaddr1(wcsaddr1), .wcsdata1(wcsdata1), .wcsaddr2(wcsaddr2), .wcsdata2(wcsdata2),
        .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // CSR file model: combinational read, port 2 written after port 1.
    always_comb begin
        case (rcsaddr)
            12'h305: rcsdata = m_mtvec;
            12'h341: rcsdata = m_mepc;
            12'h342: rcsdata = m_mcause;
            12'h300: rcsdata = m_mstatus;
            default: rcsdata = 64'h0;
        endcase
    end

    always @(posedge clk) begin
        if (csr_wen) begin
            case (wcsaddr1)
                12'h305: m_mtvec   <= wcsdata1;
                12'h341: m_mepc    <= wcsdata1;
                12'h342: m_mcause  <= wcsdata1;
                12'h300: m_mstatus <= wcsdata1;
                default: ;
            endcase
            case (wcsaddr2)
                12'h305: m_mtvec   <= wcsdata2;
                12'h341: m_mepc    <= wcsdata2;
                12'h342: m_mcause  <= wcsdata2;
                12'h300: m_mstatus <= wcsdata2;
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ecall;
        logic        mret;
        logic [63:0] pc;
        logic [63:0] mtvec;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mstatus;
        logic [63:0] exp_mepc;
        logic [63:0] exp_mcause;
        logic [63:0] exp_mstatus;
        logic [63:0] exp_pc;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic load_csrs(input logic [63:0] tv, ep, mc, ms);
        m_mtvec   = tv;
        m_mepc    = ep;
        m_mcause  = mc;
        m_mstatus = ms;
    endtask

    task automatic run_vec(input int i);
        int          lat;
        int          wen_n;
        logic [63:0] rpc;
        lat   = -1;
        wen_n = 0;
        rpc   = '0;
        @(negedge clk);
        load_csrs(vecs[i].mtvec, vecs[i].mepc, vecs[i].mcause, vecs[i].mstatus);
        req_valid = 1'b1;
        is_ecall  = vecs[i].ecall;
        is_mret   = vecs[i].mret;
        pc        = vecs[i].pc;
        #1;
        chk($sformatf("v%0d req_ready", i), {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        is_ecall  = 1'b0;
        is_mret   = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1) begin
                chk($sformatf("v%0d rcsaddr_a", i), {52'd0, rcsaddr},
                    vecs[i].ecall ? 64'h305 : 64'h341);
                chk($sformatf("v%0d busy", i), {63'd0, busy}, 64'd1);
            end
            if (csr_wen) wen_n++;
            if (redirect_valid) begin
                lat = c;
                rpc = redirect_pc;
                break;
            end
        end
        chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
        chk($sformatf("v%0d redirect_pc", i), rpc, vecs[i].exp_pc);
        chk($sformatf("v%0d wen_cycles", i), 64'(wen_n), vecs[i].ecall ? 64'd2 : 64'd1);
        chk($sformatf("v%0d mepc", i), m_mepc, vecs[i].exp_mepc);
        chk($sformatf("v%0d mcause", i), m_mcause, vecs[i].exp_mcause);
        chk($sformatf("v%0d mstatus", i), m_mstatus, vecs[i].exp_mstatus);
        @(negedge clk);
        chk($sformatf("v%0d ready_after", i), {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        logic [11:0] acc_v, red_v, wen_v;
        int          bad_ready;
        int          red_n, wen_n;

        load_csrs(64'h0, 64'h0, 64'h0, 64'h0);

        // ecall, mret, pc, mtvec, mepc, mcause, mstatus -> mepc, mcause, mstatus, redirect, latency
        vecs[0] = '{1'b1, 1'b0, 64'h80000010, 64'h80000100, 64'h0, 64'h0, 64'ha00001808,
                    64'h80000010, 64'd11, 64'ha00001880, 64'h80000100, 5};
        vecs[1] = '{1'b1, 1'b0, 64'h80000200, 64'h80000103, 64'h1234, 64'h0, 64'h0,
                    64'h80000200, 64'd11, 64'h1800, 64'h80000100, 5};
        vecs[2] = '{1'b0, 1'b1, 64'h80000300, 64'h0, 64'h80000014, 64'd7, 64'ha00001880,
                    64'h80000014, 64'd7, 64'ha00001888, 64'h80000014, 4};
        vecs[3] = '{1'b1, 1'b1, 64'h80000040, 64'h80000200, 64'h0, 64'd2, 64'h8,
                    64'h80000040, 64'd11, 64'h1880, 64'h80000200, 5};
        vecs[4] = '{1'b0, 1'b1, 64'h0, 64'h80000100, 64'h80000015, 64'd5, 64'h0,
                    64'h80000015, 64'd5, 64'h1880, 64'h80000015, 4};
        vecs[5] = '{1'b0, 1'b1, 64'h10, 64'h0, 64'h80001000, 64'd11, 64'hffffffffffffff77,
                    64'h80001000, 64'd11, 64'hfffffffffffffff7, 64'h80001000, 4};
        vecs[6] = '{1'b1, 1'b0, 64'hfffffffffffffffc, 64'hffffffffffffffff, 64'h0, 64'h0,
                    64'hffffffffffffe7f7, 64'hfffffffffffffffc, 64'd11, 64'hffffffffffffff77,
                    64'hfffffffffffffffc, 5};

        // Reset values while rst is held.
        @(negedge clk);
        @(negedge clk);
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst csr_wen", {63'd0, csr_wen}, 64'd0);
        chk("rst redirect_valid", {63'd0, redirect_valid}, 64'd0);
        chk("rst redirect_pc", redirect_pc, 64'd0);
        chk("rst wcsaddr1", {52'd0, wcsaddr1}, 64'd0);
        chk("rst wcsdata2", wcsdata2, 64'd0);
        chk("rst req_ready", {63'd0, req_ready}, 64'd1);
        rst = 1'b0;

        // req_valid without a trap-class flag is ignored.
        @(negedge clk);
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ignore busy%0d", k), {63'd0, busy}, 64'd0);
        end
        req_valid = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Back-to-back: ECALL held valid across the whole sequence.
        @(negedge clk);
        load_csrs(64'h80000100, 64'h0, 64'h0, 64'h1808);
        req_valid = 1'b1;
        is_ecall  = 1'b1;
        pc        = 64'h80000500;
        acc_v     = '0;
        red_v     = '0;
        wen_v     = '0;
        bad_ready = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            acc_v[k] = req_valid & req_ready;
            red_v[k] = redirect_valid;
            wen_v[k] = csr_wen;
            if (busy && req_ready) bad_ready++;
            if (k == 11) begin
                req_valid = 1'b0;
                is_ecall  = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b accepts", {52'd0, acc_v}, 64'h041);
        chk("b2b redirects", {52'd0, red_v}, 64'h820);
        chk("b2b writes", {52'd0, wen_v}, 64'h618);
        chk("b2b ready_while_busy", 64'(bad_ready), 64'd0);
        chk("b2b idle_after", {63'd0, busy}, 64'd0);
        chk("b2b mepc", m_mepc, 64'h80000500);

        // Reset right after the WR_EPC write commits.
        load_csrs(64'h80000100, 64'h0, 64'h0, 64'h1808);
        req_valid = 1'b1;
        is_ecall  = 1'b1;
        pc        = 64'h80000700;
        @(negedge clk);
        req_valid = 1'b0;
        is_ecall  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid wr_epc_wen", {63'd0, csr_wen}, 64'd1);
        chk("rstmid wr_epc_addr1", {52'd0, wcsaddr1}, 64'h341);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rstmid busy", {63'd0, busy}, 64'd0);
        chk("rstmid csr_wen", {63'd0, csr_wen}, 64'd0);
        chk("rstmid wcsaddr1", {52'd0, wcsaddr1}, 64'd0);
        chk("rstmid wcsdata1", wcsdata1, 64'd0);
        chk("rstmid redirect_valid", {63'd0, redirect_valid}, 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        red_n = 0;
        wen_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (redirect_valid) red_n++;
            if (csr_wen) wen_n++;
        end
        chk("rstmid no_redirect", 64'(red_n), 64'd0);
        chk("rstmid no_writes", 64'(wen_n), 64'd0);
        chk("rstmid mepc", m_mepc, 64'h80000700);
        chk("rstmid mcause", m_mcause, 64'd11);
        chk("rstmid mstatus", m_mstatus, 64'h1808);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
